// File: rtl/calendar_date_counter.sv
// Day/month/year calendar counter advanced by day_tick, with validated date loading.
// Optional weekday tracking is enabled by defining CAL_WEEKDAY_EN.
module calendar_date_counter #(
    parameter int BASE_YEAR = 2025,
    parameter int YEAR_W    = 10,
    parameter int YEAR_MAX  = 974,
    parameter int ABS_W     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              day_tick,
    input  logic              load,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
`ifdef CAL_WEEKDAY_EN
    input  logic [2:0]        load_wday,
    output logic [2:0]        wday,
`endif
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [4:0]        max_day,
    output logic              leap,
    output logic              busy,
    output logic              year_wrap,
    output logic              load_err
);

    localparam logic [8:0]        R400_RST = 9'(BASE_YEAR % 400);
    localparam logic [1:0]        BASE_LO2 = 2'(BASE_YEAR % 4);
    localparam logic [ABS_W-1:0]  BASE_ABS = ABS_W'(BASE_YEAR);
    localparam logic [ABS_W-1:0]  C400     = ABS_W'(400);
    localparam logic [YEAR_W-1:0] YMAX     = YEAR_W'(YEAR_MAX);

    typedef enum logic {S_RUN, S_CALC} state_t;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
        case (m)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: month_len = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    month_len = 5'd30;
            4'd2:                                       month_len = lp ? 5'd29 : 5'd28;
            default:                                    month_len = 5'd0;
        endcase
    endfunction

    // Divisible by 4, excluding century years that are not multiples of 400.
    function automatic logic is_leap(input logic [1:0] abs_lo2, input logic [8:0] res);
        is_leap = (abs_lo2 == 2'd0) && (res != 9'd100) && (res != 9'd200) && (res != 9'd300);
    endfunction

`ifdef CAL_WEEKDAY_EN
    // Weekday of 1 January of year y, 0 = Monday.
    function automatic int jan1_wday(input int y);
        int s;
        s = (1 + 5 * ((y - 1) % 4) + 4 * ((y - 1) % 100) + 6 * ((y - 1) % 400)) % 7;
        return (s + 6) % 7;
    endfunction
    localparam logic [2:0] WDAY_RST = 3'(jan1_wday(BASE_YEAR));
`endif

    state_t            r_state, w_state_next;
    logic [4:0]        r_day, w_day_next;
    logic [3:0]        r_month, w_month_next;
    logic [YEAR_W-1:0] r_year, w_year_next;
    logic [8:0]        r_r400, w_r400_next;
    logic [ABS_W-1:0]  r_rem, w_rem_next;
    logic              r_pending, w_pending_next;
    logic              r_year_wrap, w_year_wrap_next;
    logic              r_load_err, w_load_err_next;
    logic [2:0]        r_wday, w_wday_next;

    logic [1:0]        w_abs_lo2;
    logic              w_leap;
    logic [4:0]        w_max_day;
    logic              w_wday_ok;
    logic              w_load_ok;
    logic              w_fin_leap;

    assign w_abs_lo2  = BASE_LO2 + r_year[1:0];
    assign w_leap     = is_leap(w_abs_lo2, r_r400);
    assign w_max_day  = month_len(r_month, w_leap);
    assign w_fin_leap = is_leap(w_abs_lo2, r_rem[8:0]);

`ifdef CAL_WEEKDAY_EN
    assign w_wday_ok = (load_wday != 3'd7);
`else
    assign w_wday_ok = 1'b1;
`endif

    // Feb is accepted with 29 days here; the true length is only known after CALC.
    assign w_load_ok = (load_day != 5'd0) && (load_day <= month_len(load_month, 1'b1)) &&
                       (load_year <= YMAX) && w_wday_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_day       <= 5'd1;
            r_month     <= 4'd1;
            r_year      <= '0;
            r_r400      <= R400_RST;
            r_rem       <= '0;
            r_pending   <= 1'b0;
            r_year_wrap <= 1'b0;
            r_load_err  <= 1'b0;
`ifdef CAL_WEEKDAY_EN
            r_wday      <= WDAY_RST;
`else
            r_wday      <= 3'd0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_day       <= w_day_next;
            r_month     <= w_month_next;
            r_year      <= w_year_next;
            r_r400      <= w_r400_next;
            r_rem       <= w_rem_next;
            r_pending   <= w_pending_next;
            r_year_wrap <= w_year_wrap_next;
            r_load_err  <= w_load_err_next;
            r_wday      <= w_wday_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_day_next       = r_day;
        w_month_next     = r_month;
        w_year_next      = r_year;
        w_r400_next      = r_r400;
        w_rem_next       = r_rem;
        w_pending_next   = r_pending;
        w_year_wrap_next = 1'b0;
        w_load_err_next  = 1'b0;
        w_wday_next      = r_wday;

        if (load && w_load_ok) begin
            w_day_next     = load_day;
            w_month_next   = load_month;
            w_year_next    = load_year;
            w_rem_next     = BASE_ABS + ABS_W'(load_year);
            w_pending_next = 1'b0;
            w_state_next   = S_CALC;
`ifdef CAL_WEEKDAY_EN
            w_wday_next    = load_wday;
`endif
        end else begin
            if (load) begin
                w_load_err_next = 1'b1;
            end
            case (r_state)
                S_RUN: begin
                    w_pending_next = 1'b0;
                    // A tick alongside any load is discarded; pending and real ticks merge.
                    if (!load && (day_tick || r_pending)) begin
                        w_wday_next = (r_wday == 3'd6) ? 3'd0 : r_wday + 3'd1;
                        if (r_day < w_max_day) begin
                            w_day_next = r_day + 5'd1;
                        end else begin
                            w_day_next = 5'd1;
                            if (r_month < 4'd12) begin
                                w_month_next = r_month + 4'd1;
                            end else begin
                                w_month_next = 4'd1;
                                if (r_year == YMAX) begin
                                    w_year_next      = '0;
                                    w_r400_next      = R400_RST;
                                    w_year_wrap_next = 1'b1;
                                end else begin
                                    w_year_next = r_year + YEAR_W'(1);
                                    w_r400_next = (r_r400 == 9'd399) ? 9'd0 : r_r400 + 9'd1;
                                end
                            end
                        end
                    end
                end
                S_CALC: begin
                    if (day_tick) begin
                        w_pending_next = 1'b1;
                    end
                    if (r_rem >= C400) begin
                        w_rem_next = r_rem - C400;
                    end else begin
                        w_r400_next  = r_rem[8:0];
                        w_state_next = S_RUN;
                        if (r_month == 4'd2 && r_day == 5'd29 && !w_fin_leap) begin
                            w_day_next      = 5'd28;
                            w_load_err_next = 1'b1;
                        end
                    end
                end
                default: w_state_next = S_RUN;
            endcase
        end
    end

    assign day       = r_day;
    assign month     = r_month;
    assign year      = r_year;
    assign leap      = w_leap;
    assign max_day   = w_max_day;
    assign busy      = (r_state == S_CALC);
    assign year_wrap = r_year_wrap;
    assign load_err  = r_load_err;
`ifdef CAL_WEEKDAY_EN
    assign wday      = r_wday;
`endif

endmodule

// File: tb/tb_calendar_date_counter.sv
// Scoreboard bench for calendar_date_counter: expected dates are queued when
// stimulus is driven and compared once the DUT settles.
module tb_calendar_date_counter;

    typedef logic [19:0] rec_t;   // {day, month, year, leap}

    logic       clk = 1'b0;
    logic       rst, day_tick, load;
    logic [4:0] load_day;
    logic [3:0] load_month;
    logic [9:0] load_year;
    logic [4:0] day, max_day;
    logic [3:0] month;
    logic [9:0] year;
    logic       leap, busy, year_wrap, load_err;
`ifdef CAL_WEEKDAY_EN
    logic [2:0] load_wday, wday;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    rec_t exp_q[$];
    rec_t exp_r;
    rec_t obs;

    assign obs = {day, month, year, leap};

    calendar_date_counter dut (
        .clk        (clk),
        .rst        (rst),
        .day_tick   (day_tick),
        .load       (load),
        .load_day   (load_day),
        .load_month (load_month),
        .load_year  (load_year),
`ifdef CAL_WEEKDAY_EN
        .load_wday  (load_wday),
        .wday       (wday),
`endif
        .day        (day),
        .month      (month),
        .year       (year),
        .max_day    (max_day),
        .leap       (leap),
        .busy       (busy),
        .year_wrap  (year_wrap),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    function automatic bit abs_leap(input int a);
        return (a % 4 == 0) && ((a % 100 != 0) || (a % 400 == 0));
    endfunction

    function automatic rec_t mk(input int d, input int m, input int y);
        return {5'(d), 4'(m), 10'(y), abs_leap(2025 + y)};
    endfunction

    function automatic int mlen(input int m, input bit lp);
        case (m)
            2:             return lp ? 29 : 28;
            4, 6, 9, 11:   return 30;
            default:       return 31;
        endcase
    endfunction

    function automatic rec_t next_rec(input rec_t r);
        int d, m, y;
        d = int'(r[19:15]);
        m = int'(r[14:11]);
        y = int'(r[10:1]);
        if (d < mlen(m, abs_leap(2025 + y))) d++;
        else begin
            d = 1;
            if (m < 12) m++;
            else begin
                m = 1;
                y = (y == 974) ? 0 : y + 1;
            end
        end
        return mk(d, m, y);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int d, input int m, input int y);
        load       = 1'b1;
        load_day   = 5'(d);
        load_month = 4'(m);
        load_year  = 10'(y);
        step();
        load       = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; day_tick = 1'b0; load = 1'b0;
        load_day = 5'd0; load_month = 4'd0; load_year = 10'd0;
`ifdef CAL_WEEKDAY_EN
        load_wday = 3'd0;
`endif
        exp_q.push_back(mk(1, 1, 0));
        step(); step();
        exp_r = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp_r) begin
            n_err++; $display("FAIL reset_date: got %h expected %h", obs, exp_r);
        end
        n_cmp++;
        if ({busy, year_wrap, load_err, max_day} !== {3'b000, 5'd31}) begin
            n_err++; $display("FAIL reset_flags: got %b expected %b",
                              {busy, year_wrap, load_err, max_day}, {3'b000, 5'd31});
        end
`ifdef CAL_WEEKDAY_EN
        n_cmp++;
        if (wday !== 3'd2) begin
            n_err++; $display("FAIL reset_wday: got %0d expected 2", wday);
        end
`endif
        rst = 1'b0;
        step();
        $display("reset: date %h flags busy=%b wrap=%b err=%b", obs, busy, year_wrap, load_err);
    endtask

    task automatic test_ticks();
        rec_t cur = mk(1, 1, 0);
        day_tick = 1'b1;
        for (int i = 0; i < 59; i++) begin
            cur = next_rec(cur);
            exp_q.push_back(cur);
            step();
            exp_r = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_r) begin
                n_err++; $display("FAIL tick_%0d: got %h expected %h", i, obs, exp_r);
            end
        end
        day_tick = 1'b0;
        n_cmp++;
        if ({obs, max_day} !== {mk(1, 3, 0), 5'd31}) begin
            n_err++; $display("FAIL ticks_1mar: got %h expected %h", {obs, max_day}, {mk(1, 3, 0), 5'd31});
        end
        $display("ticks: 59 advances, now %0d/%0d/%0d leap=%b", day, month, year, leap);
    endtask

    task automatic test_leap_load();
        int cnt;
        do_load(28, 2, 3);
        exp_q.push_back(mk(28, 2, 3));
        wait_idle(cnt);
        n_cmp++;
        if (cnt !== 6) begin
            n_err++; $display("FAIL leap_busy_len: got %0d expected 6", cnt);
        end
        exp_r = exp_q.pop_front();
        n_cmp++;
        if ({obs, max_day} !== {exp_r, 5'd29}) begin
            n_err++; $display("FAIL leap_load: got %h expected %h", {obs, max_day}, {exp_r, 5'd29});
        end
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(next_rec(exp_r));
            day_tick = 1'b1; step(); day_tick = 1'b0;
            exp_r = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_r) begin
                n_err++; $display("FAIL leap_tick_%0d: got %h expected %h", i, obs, exp_r);
            end
        end
        $display("leap_load: busy %0d cycles, now %0d/%0d/%0d", cnt, day, month, year);
    endtask

    task automatic test_clamp();
        int cnt;
        do_load(29, 2, 75);
        exp_q.push_back(mk(28, 2, 75));
        wait_idle(cnt);
        exp_r = exp_q.pop_front();
        n_cmp++;
        if ({obs, load_err, 5'(cnt)} !== {exp_r, 1'b1, 5'd6}) begin
            n_err++; $display("FAIL clamp_2100: got %h expected %h", {obs, load_err, 5'(cnt)}, {exp_r, 1'b1, 5'd6});
        end
        step();
        n_cmp++;
        if (load_err !== 1'b0) begin
            n_err++; $display("FAIL clamp_err_pulse: got %b expected 0", load_err);
        end
        do_load(29, 2, 375);
        exp_q.push_back(mk(29, 2, 375));
        wait_idle(cnt);
        exp_r = exp_q.pop_front();
        n_cmp++;
        if ({obs, load_err, 5'(cnt)} !== {exp_r, 1'b0, 5'd7}) begin
            n_err++; $display("FAIL noclamp_2400: got %h expected %h", {obs, load_err, 5'(cnt)}, {exp_r, 1'b0, 5'd7});
        end
        $display("clamp: 2400 leap=%b busy %0d cycles", leap, cnt);
    endtask

    task automatic test_wrap();
        int cnt;
        do_load(31, 12, 974);
        wait_idle(cnt);
        n_cmp++;
        if (cnt !== 8) begin
            n_err++; $display("FAIL wrap_busy_len: got %0d expected 8", cnt);
        end
        exp_q.push_back(mk(1, 1, 0));
        day_tick = 1'b1; step(); day_tick = 1'b0;
        exp_r = exp_q.pop_front();
        n_cmp++;
        if ({obs, year_wrap} !== {exp_r, 1'b1}) begin
            n_err++; $display("FAIL wrap_edge: got %h expected %h", {obs, year_wrap}, {exp_r, 1'b1});
        end
        step();
        n_cmp++;
        if (year_wrap !== 1'b0) begin
            n_err++; $display("FAIL wrap_pulse: got %b expected 0", year_wrap);
        end
        $display("wrap: now %0d/%0d/%0d leap=%b", day, month, year, leap);
    endtask

    task automatic test_invalid();
        int td[3] = '{31, 5, 1};
        int tm[3] = '{4, 0, 1};
        int ty[3] = '{10, 10, 975};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(1, 1, 0));
            do_load(td[i], tm[i], ty[i]);
            exp_r = exp_q.pop_front();
            n_cmp++;
            if ({obs, load_err, busy} !== {exp_r, 2'b10}) begin
                n_err++; $display("FAIL invalid_%0d: got %h expected %h", i, {obs, load_err, busy}, {exp_r, 2'b10});
            end
            step();
            n_cmp++;
            if (load_err !== 1'b0) begin
                n_err++; $display("FAIL invalid_pulse_%0d: got %b expected 0", i, load_err);
            end
            $display("invalid: load %0d/%0d/%0d rejected", td[i], tm[i], ty[i]);
        end
    endtask

    task automatic test_pending();
        int cnt;
        do_load(30, 6, 0);
        day_tick = 1'b1; step(); step(); day_tick = 1'b0;
        exp_q.push_back(mk(30, 6, 0));
        exp_q.push_back(mk(1, 7, 0));
        exp_q.push_back(mk(1, 7, 0));
        wait_idle(cnt);
        n_cmp++;
        if (cnt !== 4) begin
            n_err++; $display("FAIL pending_busy_len: got %0d expected 4", cnt);
        end
        for (int i = 0; i < 3; i++) begin
            exp_r = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_r) begin
                n_err++; $display("FAIL pending_%0d: got %h expected %h", i, obs, exp_r);
            end
            step();
        end
        $display("pending: now %0d/%0d/%0d", day, month, year);
    endtask

    task automatic test_back_to_back();
        int cnt;
        do_load(1, 1, 974);
        day_tick = 1'b1; step(); day_tick = 1'b0;
        do_load(15, 8, 3);
        exp_q.push_back(mk(15, 8, 3));
        exp_q.push_back(mk(15, 8, 3));
        wait_idle(cnt);
        n_cmp++;
        if (cnt !== 6) begin
            n_err++; $display("FAIL restart_busy_len: got %0d expected 6", cnt);
        end
        for (int i = 0; i < 2; i++) begin
            exp_r = exp_q.pop_front();
            n_cmp++;
            if (obs !== exp_r) begin
                n_err++; $display("FAIL restart_%0d: got %h expected %h", i, obs, exp_r);
            end
            step();
        end
        load = 1'b1; day_tick = 1'b1;
        load_day = 5'd10; load_month = 4'd10; load_year = 10'd0;
        step();
        load = 1'b0; day_tick = 1'b0;
        exp_q.push_back(mk(10, 10, 0));
        wait_idle(cnt);
        step();
        exp_r = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp_r) begin
            n_err++; $display("FAIL load_beats_tick: got %h expected %h", obs, exp_r);
        end
        $display("back_to_back: now %0d/%0d/%0d", day, month, year);
    endtask

    initial begin
        test_reset();
        test_ticks();
        test_leap_load();
        test_clamp();
        test_wrap();
        test_invalid();
        test_pending();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
